// File: rtl/ub_pkg.sv
// Constants and state encoding shared by the unified buffer and the blocks that read from it.
package ub_pkg;

  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 9;
  localparam int UB_DEPTH = 50;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } ub_rd_state_t;

endpackage

// File: rtl/lane_delay.sv
// One-stage data+valid register with synchronous active-low clear; data is forced to 0 when not valid.
module lane_delay
  import ub_pkg::*;
#(
  parameter int W = DATA_W
) (
  input  logic         clk,
  input  logic         i_rst_n,
  input  logic [W-1:0] i_data,
  input  logic         i_valid,
  output logic [W-1:0] o_data,
  output logic         o_valid
);

  logic [W-1:0] r_data;
  logic         r_valid;

  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= i_valid;
      r_data  <= i_valid ? i_data : '0;
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;

endmodule

// File: rtl/ub_read_sequencer.sv
// Reads a contiguous run of words from the unified buffer two per cycle and feeds them,
// skewed by one cycle between lanes, to the two systolic-array row inputs.
module ub_read_sequencer
  import ub_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start_in,
  input  logic [ADDR_W-1:0] base_addr_in,
  input  logic [ADDR_W-1:0] num_words_in,
  output logic              ub_rd_en_out,
  output logic [ADDR_W-1:0] ub_rd_addr_1_out,
  output logic [ADDR_W-1:0] ub_rd_addr_2_out,
  input  logic [DATA_W-1:0] ub_rd_data_1_in,
  input  logic [DATA_W-1:0] ub_rd_data_2_in,
  output logic [DATA_W-1:0] sys_data_1_out,
  output logic              sys_valid_1_out,
  output logic [DATA_W-1:0] sys_data_2_out,
  output logic              sys_valid_2_out,
  output logic              busy_out,
  output logic              done_out,
  output logic              err_out,
  output logic [1:0]        dbg_state_out
);

  localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W+1)'(UB_DEPTH);

  ub_rd_state_t      r_state, w_next;
  logic [ADDR_W-1:0] r_ptr, r_pairs;
  logic              r_odd;
  logic [1:0]        r_drain;
  logic              r_err, r_zdone;
  logic              r_pend_v1, r_pend_v2;
  logic              r_s1_v, r_l2_v;
  logic [DATA_W-1:0] r_s1_d, r_l2_d;

  logic [ADDR_W:0]   w_end;
  logic [ADDR_W-1:0] w_pairs;
  logic              w_range_err, w_cmd, w_rd_en, w_l2_ok;

  // End address is one bit wider so B+N cannot wrap past the depth check.
  assign w_end       = {1'b0, base_addr_in} + {1'b0, num_words_in};
  assign w_range_err = w_end > DEPTH_EXT;
  assign w_pairs     = ADDR_W'(({1'b0, num_words_in} + 1'b1) >> 1);
  assign w_cmd       = (r_state == IDLE) && start_in;
  assign w_rd_en     = (r_state == READ);
  assign w_l2_ok     = !(r_odd && (r_pairs == ADDR_W'(1)));

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start_in && !w_range_err && (num_words_in != '0)) w_next = READ;
      READ:    if (r_pairs == ADDR_W'(1)) w_next = DRAIN;
      DRAIN:   if (r_drain == 2'd0) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_ptr     <= '0;
      r_pairs   <= '0;
      r_odd     <= 1'b0;
      r_drain   <= '0;
      r_err     <= 1'b0;
      r_zdone   <= 1'b0;
      r_pend_v1 <= 1'b0;
      r_pend_v2 <= 1'b0;
      r_s1_v    <= 1'b0;
      r_s1_d    <= '0;
      r_l2_v    <= 1'b0;
      r_l2_d    <= '0;
    end else begin
      r_state <= w_next;
      r_err   <= w_cmd && w_range_err;
      r_zdone <= w_cmd && !w_range_err && (num_words_in == '0);
      if (w_cmd) begin
        r_ptr   <= base_addr_in;
        r_pairs <= w_pairs;
        r_odd   <= num_words_in[0];
      end else if (r_state == READ) begin
        r_ptr   <= r_ptr + ADDR_W'(2);
        r_pairs <= r_pairs - ADDR_W'(1);
        r_drain <= 2'd2;
      end else if (r_state == DRAIN) begin
        r_drain <= r_drain - 2'd1;
      end
      // Valids track the read one cycle ahead of the buffer's data.
      r_pend_v1 <= w_rd_en;
      r_pend_v2 <= w_rd_en && w_l2_ok;
      r_s1_v    <= r_pend_v1;
      r_s1_d    <= r_pend_v1 ? ub_rd_data_1_in : '0;
      r_l2_v    <= r_pend_v2;
      r_l2_d    <= r_pend_v2 ? ub_rd_data_2_in : '0;
    end
  end

  lane_delay #(.W(DATA_W)) u_lane2_skew (
    .clk     (clk),
    .i_rst_n (rst),
    .i_data  (r_l2_d),
    .i_valid (r_l2_v),
    .o_data  (sys_data_2_out),
    .o_valid (sys_valid_2_out)
  );

  assign ub_rd_en_out     = w_rd_en;
  assign ub_rd_addr_1_out = w_rd_en ? r_ptr : '0;
  assign ub_rd_addr_2_out = w_rd_en ? (r_ptr + ADDR_W'(1)) : '0;
  assign sys_data_1_out   = r_s1_d;
  assign sys_valid_1_out  = r_s1_v;
  assign busy_out         = (r_state != IDLE);
  assign done_out         = (r_state == DONE) || r_zdone;
  assign err_out          = r_err;
  assign dbg_state_out    = r_state;

endmodule

// File: tb/tb_ub_read_sequencer.sv
// Directed bench for ub_read_sequencer: cycle-by-cycle snapshots of all outputs vs hand-built tables.
module tb_ub_read_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_in = 1'b0;
  logic [8:0]  base_addr_in = '0;
  logic [8:0]  num_words_in = '0;
  logic        ub_rd_en_out;
  logic [8:0]  ub_rd_addr_1_out, ub_rd_addr_2_out;
  logic [15:0] ub_rd_data_1_in = '0, ub_rd_data_2_in = '0;
  logic [15:0] sys_data_1_out, sys_data_2_out;
  logic        sys_valid_1_out, sys_valid_2_out;
  logic        busy_out, done_out, err_out;
  logic [1:0]  dbg_state_out;

  typedef struct packed {
    logic [1:0]  st;
    logic        rd;
    logic [8:0]  a1;
    logic [8:0]  a2;
    logic        v1;
    logic [15:0] d1;
    logic        v2;
    logic [15:0] d2;
    logic        busy;
    logic        done;
    logic        err;
  } snap_t;

  snap_t       obs [0:11];
  snap_t       exp_t [0:11];
  logic [15:0] mem [0:63];
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  ub_read_sequencer dut (
    .clk              (clk),
    .rst              (rst),
    .start_in         (start_in),
    .base_addr_in     (base_addr_in),
    .num_words_in     (num_words_in),
    .ub_rd_en_out     (ub_rd_en_out),
    .ub_rd_addr_1_out (ub_rd_addr_1_out),
    .ub_rd_addr_2_out (ub_rd_addr_2_out),
    .ub_rd_data_1_in  (ub_rd_data_1_in),
    .ub_rd_data_2_in  (ub_rd_data_2_in),
    .sys_data_1_out   (sys_data_1_out),
    .sys_valid_1_out  (sys_valid_1_out),
    .sys_data_2_out   (sys_data_2_out),
    .sys_valid_2_out  (sys_valid_2_out),
    .busy_out         (busy_out),
    .done_out         (done_out),
    .err_out          (err_out),
    .dbg_state_out    (dbg_state_out)
  );

  // Buffer model: data valid the cycle after the read request.
  always @(posedge clk) begin
    if (ub_rd_en_out) begin
      ub_rd_data_1_in <= mem[ub_rd_addr_1_out[5:0]];
      ub_rd_data_2_in <= mem[ub_rd_addr_2_out[5:0]];
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  function automatic snap_t capture();
    snap_t s;
    s.st   = dbg_state_out;
    s.rd   = ub_rd_en_out;
    s.a1   = ub_rd_addr_1_out;
    s.a2   = ub_rd_addr_2_out;
    s.v1   = sys_valid_1_out;
    s.d1   = sys_data_1_out;
    s.v2   = sys_valid_2_out;
    s.d2   = sys_data_2_out;
    s.busy = busy_out;
    s.done = done_out;
    s.err  = err_out;
    return s;
  endfunction

  // Cycle 0 carries the start strobe; extra starts at s2/s3 use base b2; rst low during cycle rst_c.
  task automatic run_cmd(input logic [8:0] b, input logic [8:0] n, input int s2, input int s3,
                         input logic [8:0] b2, input int rst_c);
    obs[0] = capture();
    start_in = 1'b1;
    base_addr_in = b;
    num_words_in = n;
    for (int c = 1; c < 12; c++) begin
      step();
      obs[c] = capture();
      start_in = (c == s2) || (c == s3);
      if (start_in) base_addr_in = b2;
      rst = (c == rst_c) ? 1'b0 : 1'b1;
    end
    start_in = 1'b0;
    rst = 1'b1;
    idle_cycles(10);
  endtask

  task automatic clear_exp();
    for (int i = 0; i < 12; i++) exp_t[i] = '0;
  endtask

  // Hand table for a 4-word run started in cycle off at base b with words w0..w3.
  task automatic fill_run4(input int off, input logic [8:0] b, input logic [15:0] w0,
                           input logic [15:0] w1, input logic [15:0] w2, input logic [15:0] w3);
    for (int k = 1; k <= 6; k++) begin
      if (off + k < 12) begin
        exp_t[off+k].busy = 1'b1;
        exp_t[off+k].st   = (k <= 2) ? 2'd1 : (k <= 5) ? 2'd2 : 2'd3;
        exp_t[off+k].done = (k == 6);
      end
    end
    if (off + 1 < 12) begin exp_t[off+1].rd = 1'b1; exp_t[off+1].a1 = b;      exp_t[off+1].a2 = b + 9'd1; end
    if (off + 2 < 12) begin exp_t[off+2].rd = 1'b1; exp_t[off+2].a1 = b + 9'd2; exp_t[off+2].a2 = b + 9'd3; end
    if (off + 3 < 12) begin exp_t[off+3].v1 = 1'b1; exp_t[off+3].d1 = w0; end
    if (off + 4 < 12) begin exp_t[off+4].v1 = 1'b1; exp_t[off+4].d1 = w2; end
    if (off + 4 < 12) begin exp_t[off+4].v2 = 1'b1; exp_t[off+4].d2 = w1; end
    if (off + 5 < 12) begin exp_t[off+5].v2 = 1'b1; exp_t[off+5].d2 = w3; end
  endtask

  task automatic test_reset();
    snap_t s;
    rst = 1'b0;
    idle_cycles(3);
    s = capture();
    tests++;
    if (s !== snap_t'('0)) begin
      fails++;
      $display("FAIL reset: got %h expected %h", s, snap_t'('0));
    end
    rst = 1'b1;
    idle_cycles(2);
  endtask

  task automatic test_even_run();
    clear_exp();
    fill_run4(0, 9'd0, 16'h0011, 16'h0022, 16'h0033, 16'h0044);
    run_cmd(9'd0, 9'd4, -1, -1, 9'd0, -1);
    for (int c = 0; c < 12; c++) begin
      tests++;
      if (obs[c] !== exp_t[c]) begin
        fails++;
        $display("FAIL even_run c%0d: got %h expected %h", c, obs[c], exp_t[c]);
      end
    end
  endtask

  task automatic test_odd_run();
    clear_exp();
    fill_run4(0, 9'd10, 16'h000A, 16'h000B, 16'h000C, 16'h0000);
    exp_t[5].v2 = 1'b0;
    run_cmd(9'd10, 9'd3, -1, -1, 9'd0, -1);
    for (int c = 0; c < 12; c++) begin
      tests++;
      if (obs[c] !== exp_t[c]) begin
        fails++;
        $display("FAIL odd_run c%0d: got %h expected %h", c, obs[c], exp_t[c]);
      end
    end
  endtask

  task automatic test_range();
    clear_exp();
    exp_t[1].err = 1'b1;
    run_cmd(9'd48, 9'd4, -1, -1, 9'd0, -1);
    for (int c = 0; c < 12; c++) begin
      tests++;
      if (obs[c] !== exp_t[c]) begin
        fails++;
        $display("FAIL range_err c%0d: got %h expected %h", c, obs[c], exp_t[c]);
      end
    end
    clear_exp();
    fill_run4(0, 9'd46, 16'h012E, 16'h012F, 16'h0130, 16'h0131);
    run_cmd(9'd46, 9'd4, -1, -1, 9'd0, -1);
    for (int c = 0; c < 12; c++) begin
      tests++;
      if (obs[c] !== exp_t[c]) begin
        fails++;
        $display("FAIL range_edge c%0d: got %h expected %h", c, obs[c], exp_t[c]);
      end
    end
  endtask

  task automatic test_zero_len();
    clear_exp();
    exp_t[1].done = 1'b1;
    run_cmd(9'd5, 9'd0, -1, -1, 9'd0, -1);
    for (int c = 0; c < 12; c++) begin
      tests++;
      if (obs[c] !== exp_t[c]) begin
        fails++;
        $display("FAIL zero_len c%0d: got %h expected %h", c, obs[c], exp_t[c]);
      end
    end
  endtask

  task automatic test_back_to_back();
    clear_exp();
    fill_run4(0, 9'd0, 16'h0011, 16'h0022, 16'h0033, 16'h0044);
    fill_run4(7, 9'd20, 16'h0114, 16'h0115, 16'h0116, 16'h0117);
    run_cmd(9'd0, 9'd4, 2, 7, 9'd20, -1);
    for (int c = 0; c < 12; c++) begin
      tests++;
      if (obs[c] !== exp_t[c]) begin
        fails++;
        $display("FAIL start_busy c%0d: got %h expected %h", c, obs[c], exp_t[c]);
      end
    end
  endtask

  task automatic test_mid_reset();
    clear_exp();
    fill_run4(0, 9'd0, 16'h0011, 16'h0022, 16'h0033, 16'h0044);
    for (int c = 4; c < 12; c++) exp_t[c] = '0;
    run_cmd(9'd0, 9'd4, -1, -1, 9'd0, 3);
    for (int c = 0; c < 12; c++) begin
      tests++;
      if (obs[c] !== exp_t[c]) begin
        fails++;
        $display("FAIL mid_reset c%0d: got %h expected %h", c, obs[c], exp_t[c]);
      end
    end
    clear_exp();
    fill_run4(0, 9'd0, 16'h0011, 16'h0022, 16'h0033, 16'h0044);
    run_cmd(9'd0, 9'd4, -1, -1, 9'd0, -1);
    for (int c = 0; c < 12; c++) begin
      tests++;
      if (obs[c] !== exp_t[c]) begin
        fails++;
        $display("FAIL post_reset c%0d: got %h expected %h", c, obs[c], exp_t[c]);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 16'h0100 + 16'(i);
    mem[0]  = 16'h0011;
    mem[1]  = 16'h0022;
    mem[2]  = 16'h0033;
    mem[3]  = 16'h0044;
    mem[10] = 16'h000A;
    mem[11] = 16'h000B;
    mem[12] = 16'h000C;
    test_reset();
    test_even_run();
    test_odd_run();
    test_range();
    test_zero_len();
    test_back_to_back();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ub_read_sequencer.md
Name: ub_read_sequencer

Overview:
- Downstream consumer of the unified buffer. On a start command it reads a contiguous run of 16-bit words from the buffer's two-lane read port, two words per cycle.
- It presents the words to the two systolic-array row inputs. Lane 2 lags lane 1 by one cycle to form the systolic input skew.
- It reports busy, done and range-error status to the top-level controller.

Parameters:
- UB_DEPTH, 50, number of 16-bit words in the unified buffer; legal addresses are 0..UB_DEPTH-1.
- DATA_W, 16, word width.
- ADDR_W, 9, address and word-count width.

Ports:
- clk  in  1  single clock, all logic on its rising edge.
- rst  in  1  synchronous, active-low reset.
- start_in  in  1  command strobe; sampled only in IDLE.
- base_addr_in  in  ADDR_W  first word address; captured with start.
- num_words_in  in  ADDR_W  word count N; captured with start.
- ub_rd_en_out  out  1  read request to the buffer.
- ub_rd_addr_1_out  out  ADDR_W  lane-1 read address.
- ub_rd_addr_2_out  out  ADDR_W  lane-2 read address (lane-1 address + 1).
- ub_rd_data_1_in  in  DATA_W  lane-1 read data; valid the cycle after ub_rd_en_out.
- ub_rd_data_2_in  in  DATA_W  lane-2 read data; same timing as lane 1.
- sys_data_1_out  out  DATA_W  row-1 operand.
- sys_valid_1_out  out  1  row-1 operand valid.
- sys_data_2_out  out  DATA_W  row-2 operand, one-cycle skew behind row 1.
- sys_valid_2_out  out  1  row-2 operand valid.
- busy_out  out  1  a command is in progress.
- done_out  out  1  one-cycle pulse at command completion.
- err_out  out  1  one-cycle pulse when a command is rejected.

Behaviour:
- Reset (rst=0 at a clock edge):
  - FSM returns to IDLE; all outputs go to 0.
  - In-flight reads and pipeline contents are discarded.
  - Applies even in the middle of a command.
- FSM states: IDLE, READ, DRAIN, DONE.
- IDLE: start_in=1 at cycle 0 captures base address B and count N, computing the end address at ADDR_W+1 bits.
  - If B+N > UB_DEPTH: err_out=1 in cycle 1, no reads issued, FSM stays in IDLE, busy_out stays 0.
  - Else if N=0: done_out=1 in cycle 1, no reads issued, busy_out stays 0.
  - Otherwise: go to READ; busy_out=1 from cycle 1 through the DONE cycle inclusive.
- READ: P = ceil(N/2) cycles (cycles 1..P).
  - Each cycle asserts ub_rd_en_out with addr_1 = ptr and addr_2 = ptr+1, then ptr += 2. ptr starts at B.
  - When N is odd, the last pair's lane-2 word is marked invalid. The address is still driven, and is always in range or equal to UB_DEPTH; memory ignores it.
- Data path, for a read issued in cycle t:
  - Lane 1 is registered: sys_data_1_out / sys_valid_1_out valid in cycle t+2.
  - Lane 2 passes through one extra delay stage: valid in cycle t+3.
  - Data outputs are 0 whenever their valid is 0.
- DRAIN: entered in cycle P+1; stays until the last lane-2 slot (cycle P+3) has been emitted.
- DONE: cycle P+4; done_out=1 for that cycle, then return to IDLE. A new start is accepted from cycle P+5.
- start_in is ignored while busy_out=1; captured inputs do not change mid-command.
- No backpressure: the downstream array accepts one operand per lane per cycle.

Decomposition:
- Shared package ub_pkg holds:
  - DATA_W, ADDR_W and UB_DEPTH constants, common to the unified buffer and this block.
  - the ub_rd_state_t enum {IDLE, READ, DRAIN, DONE}.
- One sub-module, lane_delay: a single-stage data+valid register with synchronous active-low clear.
  - Instantiated once for the lane-2 skew stage.
  - Reused later for deeper array skew chains.

Test Plan:
- Even run. Buffer words 0..3 = 0x0011, 0x0022, 0x0033, 0x0044; start B=0, N=4 in cycle 0.
  - rd_en in cycles 1-2 with addr pairs (0,1) then (2,3).
  - Lane 1 = 0x0011 in cycle 3, 0x0033 in cycle 4.
  - Lane 2 = 0x0022 in cycle 4, 0x0044 in cycle 5.
  - done_out in cycle 6; busy_out in cycles 1-6.
- Odd run. B=10, N=3 (words 0xA, 0xB, 0xC).
  - Lane 1 = 0xA in cycle 3, 0xC in cycle 4.
  - Lane 2 = 0xB in cycle 4 only; sys_valid_2_out=0 in cycle 5.
  - done_out in cycle 6.
- Range error. B=48, N=4: err_out=1 in cycle 1, ub_rd_en_out never asserted, busy_out=0. B=46, N=4 is accepted.
- Zero length. N=0: done_out in cycle 1, no reads issued, busy_out=0.
- Start while busy. A second start_in (B=20) in cycle 2 of the even run is ignored; output matches the even-run case exactly. A start in cycle 7 is accepted.
- Mid-command reset. rst=0 in cycle 3 of the even run.
  - All outputs are 0 from cycle 4 and FSM is in IDLE.
  - No done_out pulse.
  - A fresh start after reset release produces a clean run.
